// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, NOP encoding and queue entry layout for the fetch queue
package fetch_pkg;
  localparam int XLEN_C = 32;
  localparam logic [XLEN_C-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN_C-1:0] pc;
    logic [XLEN_C-1:0] instr;
  } fq_entry_t;
endpackage

// File: rtl/fq_storage.sv
// fq_storage: unreset entry array with two write ports at tail and two async read ports at head
module fq_storage
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic [1:0]           we,
  input  logic [AW-1:0]        waddr,
  input  fq_entry_t [1:0]      wdata,
  input  logic [AW-1:0]        raddr,
  output fq_entry_t [1:0]      rdata
);
  fq_entry_t mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we[0]) mem[waddr] <= wdata[0];
    if (we[1]) mem[waddr + AW'(1)] <= wdata[1];
  end
  assign rdata[0] = mem[raddr];
  assign rdata[1] = mem[raddr + AW'(1)];
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: 2-wide in-order instruction buffer between fetch and dual decode
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN = XLEN_C,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [1:0]        enq_valid_i,
  input  logic [2*XLEN-1:0] enq_instr_i,
  input  logic [2*XLEN-1:0] enq_pc_i,
  output logic              enq_ready_o,
  output logic [1:0]        deq_valid_o,
  output logic [2*XLEN-1:0] deq_instr_o,
  output logic [2*XLEN-1:0] deq_pc_o,
  input  logic [1:0]        deq_accept_i,
  output logic [CW-1:0]     count_o
);
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count, enq_n, deq_n;
  logic enq_fire;
  fq_entry_t [1:0] wdata, rdata;
  assign enq_ready_o = count <= CW'(DEPTH - 2);
  assign enq_fire = enq_ready_o & enq_valid_i[0] & ~flush_i & ~rst_i;
  assign enq_n = enq_fire ? (enq_valid_i[1] ? CW'(2) : CW'(1)) : '0;
  assign deq_valid_o = {count >= CW'(2), count != '0};
  assign deq_n = CW'(deq_accept_i[0] & deq_valid_o[0]) + CW'(deq_accept_i[0] & deq_accept_i[1] & deq_valid_o[1]);
  assign wdata[0] = '{pc: enq_pc_i[XLEN-1:0], instr: enq_instr_i[XLEN-1:0]};
  assign wdata[1] = '{pc: enq_pc_i[2*XLEN-1:XLEN], instr: enq_instr_i[2*XLEN-1:XLEN]};
  fq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk(clk_i),
    .we({enq_fire & enq_valid_i[1], enq_fire}),
    .waddr(tail),
    .wdata(wdata),
    .raddr(head),
    .rdata(rdata)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + deq_n[AW-1:0];
      tail <= tail + enq_n[AW-1:0];
      count <= count + enq_n - deq_n;
    end
  end
  always_ff @(posedge clk_i) assert (rst_i || enq_valid_i != 2'b10);
  assign count_o = count;
  assign deq_instr_o = {deq_valid_o[1] ? rdata[1].instr : NOP_INSTR,
                        deq_valid_o[0] ? rdata[0].instr : NOP_INSTR};
  assign deq_pc_o = {deq_valid_o[1] ? rdata[1].pc : {XLEN{1'b0}},
                     deq_valid_o[0] ? rdata[0].pc : {XLEN{1'b0}}};
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed vector table, wrap sequence and random run against a queue model
module tb_inst_fetch_queue;
  import fetch_pkg::*;
  localparam int DEPTH = 8;
  localparam int XLEN = 32;
  localparam int CW = $clog2(DEPTH) + 1;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0, flush_i = 1'b0;
  logic [1:0] enq_valid_i = '0, deq_accept_i = '0;
  logic [2*XLEN-1:0] enq_instr_i = '0, enq_pc_i = '0;
  logic enq_ready_o;
  logic [1:0] deq_valid_o;
  logic [2*XLEN-1:0] deq_instr_o, deq_pc_o;
  logic [CW-1:0] count_o;
  int tests = 0, fails = 0;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t q[$];
  typedef struct {
    logic r, f;
    logic [1:0] ev, acc;
    logic [31:0] i0, p0, i1, p1;
    int ecount;
    logic eready;
    logic [1:0] evalid;
    logic [31:0] ei0, ep0, ei1, ep1;
  } vec_t;
  vec_t vt[17];

  inst_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .enq_valid_i(enq_valid_i), .enq_instr_i(enq_instr_i), .enq_pc_i(enq_pc_i),
    .enq_ready_o(enq_ready_o), .deq_valid_o(deq_valid_o),
    .deq_instr_o(deq_instr_o), .deq_pc_o(deq_pc_o),
    .deq_accept_i(deq_accept_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic f, logic [1:0] ev, logic [1:0] acc,
                       logic [31:0] i0, logic [31:0] p0, logic [31:0] i1, logic [31:0] p1);
    int n;
    bit rdy;
    @(negedge clk_i);
    rst_i = r;
    flush_i = f;
    enq_valid_i = ev;
    deq_accept_i = acc;
    enq_instr_i = {i1, i0};
    enq_pc_i = {p1, p0};
    n = 0;
    rdy = q.size() <= DEPTH - 2;
    if (r || f) q.delete();
    else begin
      if (acc[0] && q.size() >= 1) n = (acc[1] && q.size() >= 2) ? 2 : 1;
      repeat (n) void'(q.pop_front());
      if (rdy && ev[0]) begin
        q.push_back('{p0, i0});
        if (ev[1]) q.push_back('{p1, i1});
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_model(string tag);
    ent_t e0, e1;
    e0 = q.size() >= 1 ? q[0] : '{32'h0, NOP_INSTR};
    e1 = q.size() >= 2 ? q[1] : '{32'h0, NOP_INSTR};
    chk({tag, " count"}, 64'(count_o), 64'(q.size()));
    chk({tag, " ready"}, 64'(enq_ready_o), 64'(q.size() <= DEPTH - 2));
    chk({tag, " valid"}, 64'(deq_valid_o), 64'({q.size() >= 2, q.size() >= 1}));
    chk({tag, " lane0"}, {deq_pc_o[31:0], deq_instr_o[31:0]}, {e0.pc, e0.instr});
    chk({tag, " lane1"}, {deq_pc_o[63:32], deq_instr_o[63:32]}, {e1.pc, e1.instr});
  endtask

  function automatic vec_t mk(logic r, logic f, logic [1:0] ev, logic [1:0] acc,
                              logic [31:0] i0, logic [31:0] p0, logic [31:0] i1, logic [31:0] p1,
                              int ecount, logic eready, logic [1:0] evalid,
                              logic [31:0] ei0, logic [31:0] ep0, logic [31:0] ei1, logic [31:0] ep1);
    mk = '{r, f, ev, acc, i0, p0, i1, p1, ecount, eready, evalid, ei0, ep0, ei1, ep1};
  endfunction

  initial begin
    logic [31:0] pc, exp_pc;
    logic [1:0] ev;
    logic [31:0] nop;
    nop = NOP_INSTR;
    vt[0]  = mk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, nop, 0, nop, 0);
    vt[1]  = mk(1, 0, 2'b11, 2'b11, 1, 2, 3, 4, 0, 1, 2'b00, nop, 0, nop, 0);
    vt[2]  = mk(0, 0, 2'b11, 2'b00, 32'h00500093, 32'h0, 32'h00A00113, 32'h4,
                2, 1, 2'b11, 32'h00500093, 32'h0, 32'h00A00113, 32'h4);
    vt[3]  = mk(0, 0, 2'b00, 2'b11, 0, 0, 0, 0, 0, 1, 2'b00, nop, 0, nop, 0);
    vt[4]  = mk(0, 0, 2'b11, 2'b00, 32'hA0, 32'h100, 32'hA1, 32'h104, 2, 1, 2'b11, 32'hA0, 32'h100, 32'hA1, 32'h104);
    vt[5]  = mk(0, 0, 2'b11, 2'b00, 32'hA2, 32'h108, 32'hA3, 32'h10C, 4, 1, 2'b11, 32'hA0, 32'h100, 32'hA1, 32'h104);
    vt[6]  = mk(0, 0, 2'b11, 2'b00, 32'hA4, 32'h110, 32'hA5, 32'h114, 6, 1, 2'b11, 32'hA0, 32'h100, 32'hA1, 32'h104);
    vt[7]  = mk(0, 0, 2'b01, 2'b00, 32'hA6, 32'h118, 0, 0, 7, 0, 2'b11, 32'hA0, 32'h100, 32'hA1, 32'h104);
    vt[8]  = mk(0, 0, 2'b11, 2'b00, 32'hB0, 32'h200, 32'hB1, 32'h204, 7, 0, 2'b11, 32'hA0, 32'h100, 32'hA1, 32'h104);
    vt[9]  = mk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, nop, 0, nop, 0);
    vt[10] = mk(0, 0, 2'b01, 2'b00, 32'h00100093, 32'h200, 0, 0, 1, 1, 2'b01, 32'h00100093, 32'h200, nop, 0);
    vt[11] = mk(0, 0, 2'b00, 2'b11, 0, 0, 0, 0, 0, 1, 2'b00, nop, 0, nop, 0);
    vt[12] = mk(0, 0, 2'b11, 2'b00, 32'hC0, 32'h300, 32'hC1, 32'h304, 2, 1, 2'b11, 32'hC0, 32'h300, 32'hC1, 32'h304);
    vt[13] = mk(0, 0, 2'b11, 2'b00, 32'hC2, 32'h308, 32'hC3, 32'h30C, 4, 1, 2'b11, 32'hC0, 32'h300, 32'hC1, 32'h304);
    vt[14] = mk(0, 0, 2'b01, 2'b00, 32'hC4, 32'h310, 0, 0, 5, 1, 2'b11, 32'hC0, 32'h300, 32'hC1, 32'h304);
    vt[15] = mk(0, 1, 2'b11, 2'b11, 32'hD0, 32'h400, 32'hD1, 32'h404, 0, 1, 2'b00, nop, 0, nop, 0);
    vt[16] = mk(0, 0, 2'b11, 2'b00, 32'hE0, 32'h500, 32'hE1, 32'h504, 2, 1, 2'b11, 32'hE0, 32'h500, 32'hE1, 32'h504);
    foreach (vt[i]) begin
      drive(vt[i].r, vt[i].f, vt[i].ev, vt[i].acc, vt[i].i0, vt[i].p0, vt[i].i1, vt[i].p1);
      chk($sformatf("vec%0d count", i), 64'(count_o), 64'(vt[i].ecount));
      chk($sformatf("vec%0d ready", i), 64'(enq_ready_o), 64'(vt[i].eready));
      chk($sformatf("vec%0d valid", i), 64'(deq_valid_o), 64'(vt[i].evalid));
      chk($sformatf("vec%0d lane0", i), {deq_pc_o[31:0], deq_instr_o[31:0]}, {vt[i].ep0, vt[i].ei0});
      chk($sformatf("vec%0d lane1", i), {deq_pc_o[63:32], deq_instr_o[63:32]}, {vt[i].ep1, vt[i].ei1});
    end
    drive(1, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    pc = 32'h1000;
    exp_pc = 32'h1000;
    repeat (3) begin
      drive(0, 0, 2'b11, 2'b00, pc ^ 32'h55, pc, (pc + 4) ^ 32'h55, pc + 4);
      pc += 8;
    end
    chk("wrap prefill count", 64'(count_o), 64'd6);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("wrap%0d pc0", k), 64'(deq_pc_o[31:0]), 64'(exp_pc));
      chk($sformatf("wrap%0d pc1", k), 64'(deq_pc_o[63:32]), 64'(exp_pc + 4));
      chk($sformatf("wrap%0d instr0", k), 64'(deq_instr_o[31:0]), 64'(exp_pc ^ 32'h55));
      drive(0, 0, 2'b11, 2'b11, pc ^ 32'h55, pc, (pc + 4) ^ 32'h55, pc + 4);
      pc += 8;
      exp_pc += 8;
      chk($sformatf("wrap%0d count", k), 64'(count_o), 64'd6);
    end
    check_model("wrap end");
    for (int k = 0; k < 3000; k++) begin
      ev = ($urandom_range(2) == 0) ? 2'b00 : ($urandom_range(1) ? 2'b11 : 2'b01);
      drive($urandom_range(63) == 0, $urandom_range(31) == 0, ev, 2'($urandom),
            $urandom, pc, $urandom, pc + 4);
      pc += 8;
      check_model($sformatf("rand%0d", k));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
